// File: rtl/filter_glb_read_ctrl.sv
// filter_glb_read_ctrl
// Turns (filter, channel, row, column) index tuples into filter-GLB reads and
// streams the returned words to the NoC through a small output FIFO.
// Pipeline: acceptance -> stage A (address register / read strobe) ->
// read pending (data returns) -> FIFO push.
// Optional feature macro: FILTER_ADDR_CHECK_EN adds the sticky addr_error
// output and per-index range checks (out-of-range tuples read address 0).
module filter_glb_read_ctrl #(
    parameter int R_WIDTH    = 4,
    parameter int S_WIDTH    = 6,
    parameter int F_WIDTH    = 8,
    parameter int C_WIDTH    = 5,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  idx_valid,
    output logic                  await,
    input  logic [F_WIDTH-1:0]    filter_index,
    input  logic [C_WIDTH-1:0]    channel_index,
    input  logic [R_WIDTH-1:0]    row_index,
    input  logic [S_WIDTH-1:0]    col_index,
    input  logic [F_WIDTH-1:0]    M,
    input  logic [C_WIDTH-1:0]    C,
    input  logic [R_WIDTH-1:0]    R,
    input  logic [S_WIDTH-1:0]    S,
    output logic                  glb_rd_en,
    output logic [ADDR_WIDTH-1:0] glb_rd_addr,
    input  logic [DATA_WIDTH-1:0] glb_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [15:0]           word_count,
    output logic                  busy
`ifdef FILTER_ADDR_CHECK_EN
    ,
    output logic                  addr_error
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_THR = (CNT_W + 1)'(FIFO_DEPTH);

    logic                  a_valid;
    logic                  rp_valid;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [1:0]            inflight;
    logic [CNT_W:0]        occupancy;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_calc;
    logic [ADDR_WIDTH-1:0] addr_next;

`ifdef FILTER_ADDR_CHECK_EN
    logic range_err;
`else
    // M only feeds the range check, which is absent in this build.
    logic unused_m;
    assign unused_m = ^M;
`endif

    // Credit-based back-pressure and stream-side handshake, all from registered state.
    always_comb begin
        inflight  = {1'b0, a_valid} + {1'b0, rp_valid};
        occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
        await     = (occupancy >= DEPTH_THR);
        accept    = idx_valid & ~await;
        push      = rp_valid;
        out_valid = (fifo_count != '0);
        pop       = out_valid & out_ready;
        out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
        busy      = (inflight != 2'd0) | out_valid;
        glb_rd_en = a_valid;
    end

    // Linear filter address; arithmetic modulo 2^ADDR_WIDTH yields exactly the
    // low bits of the full-precision result, so no wide intermediate is needed.
    always_comb begin
        addr_calc = ADDR_WIDTH'(filter_index) * ADDR_WIDTH'(C) + ADDR_WIDTH'(channel_index);
        addr_calc = addr_calc * ADDR_WIDTH'(R) + ADDR_WIDTH'(row_index);
        addr_calc = addr_calc * ADDR_WIDTH'(S) + ADDR_WIDTH'(col_index);
`ifdef FILTER_ADDR_CHECK_EN
        range_err = (filter_index >= M) | (channel_index >= C) |
                    (row_index >= R) | (col_index >= S);
        addr_next = range_err ? '0 : addr_calc;
`else
        addr_next = addr_calc;
`endif
    end

    // Stage A (address register doubling as glb_rd_addr) and read-pending stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_valid     <= 1'b0;
            rp_valid    <= 1'b0;
            glb_rd_addr <= '0;
        end else begin
            a_valid  <= accept;
            rp_valid <= a_valid;
            if (accept) begin
                glb_rd_addr <= addr_next;
            end
        end
    end

    // FIFO storage; returned read data is written straight into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= glb_rd_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Popped-word statistic; start wins over a coincident pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_count <= '0;
        end else if (start) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + 16'd1;
        end
    end

`ifdef FILTER_ADDR_CHECK_EN
    // Sticky out-of-range flag, set when an offending tuple enters stage A.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_error <= 1'b0;
        end else if (start) begin
            addr_error <= 1'b0;
        end else if (accept && range_err) begin
            addr_error <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/filter_glb_read_ctrl.md
FILTER_GLB_READ_CTRL -- requirements
Module: filter_glb_read_ctrl

Interface
REQ-001 SHALL have parameters: R_WIDTH, 4, row index width; S_WIDTH, 6, column index width; F_WIDTH, 8, filter index width; C_WIDTH, 5, channel index width; ADDR_WIDTH, 16, GLB address width; DATA_WIDTH, 16, filter word width; FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2).
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-low reset.
REQ-004 SHALL have ports: start  in  1  pulse that clears statistics and the error flag; idx_valid  in  1  index tuple present, driven by generator busy; await  out  1  back-pressure to generator.
REQ-005 SHALL have ports: filter_index  in  F_WIDTH; channel_index  in  C_WIDTH; row_index  in  R_WIDTH; col_index  in  S_WIDTH  index tuple.
REQ-006 SHALL have ports: M  in  F_WIDTH  filters total; C  in  C_WIDTH  channels total; R  in  R_WIDTH  filter rows; S  in  S_WIDTH  filter columns; all held stable while busy.
REQ-007 SHALL have ports: glb_rd_en  out  1; glb_rd_addr  out  ADDR_WIDTH; glb_rd_data  in  DATA_WIDTH, valid exactly one cycle after glb_rd_en.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  DATA_WIDTH  NoC-side stream; word_count  out  16  words popped since start; busy  out  1  any entry in flight or buffered.

Function
REQ-009 SHALL accept a tuple when idx_valid=1 and await=0; accepted tuples are never dropped or reordered.
REQ-010 SHALL compute addr = ((filter_index*C + channel_index)*R + row_index)*S + col_index at full precision, truncate to ADDR_WIDTH LSBs, and register it (stage A, 1 cycle).
REQ-011 SHALL drive glb_rd_en=1 with glb_rd_addr from stage A the cycle after acceptance; stage B captures glb_rd_data one cycle later and pushes it to the FIFO.
REQ-012 SHALL deliver acceptance-to-out_valid latency of 3 cycles when the FIFO is empty and out_ready=1.
REQ-013 SHALL define inflight = valid(stage A) + valid(read pending), range 0..2, and drive await = 1 when fifo_count + inflight ≥ FIFO_DEPTH (combinational from registered state only; pop in the same cycle not credited).
REQ-014 SHALL never overflow the FIFO; push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-015 SHALL use out_valid = (fifo_count ≠ 0), out_data = FIFO head, and pop when out_valid & out_ready.
REQ-016 SHALL increment word_count by 1 per pop, wrap 0xFFFF→0, and clear on start; if start coincides with a pop, word_count SHALL be 0.
REQ-017 SHALL hold glb_rd_en=0 and glb_rd_addr at its last value when stage A is empty.
REQ-018 SHALL drive busy = (inflight ≠ 0) | (fifo_count ≠ 0).
REQ-019 SHALL keep start from flushing the pipeline or FIFO; in-flight data completes.

Reset
REQ-020 SHALL, on reset=0 at a rising edge, clear stage valids, the FIFO pointers and count, word_count and addr_error, and set glb_rd_addr=0; outputs then read await=0, glb_rd_en=0, out_valid=0, busy=0, out_data=0.
REQ-021 SHALL discard all in-flight and buffered data when reset is asserted mid-operation; the first accepted tuple after release behaves as in REQ-012.

Configuration
REQ-022 SHALL, with FILTER_ADDR_CHECK_EN defined, add port addr_error  out  1, set sticky at stage A when filter_index≥M, channel_index≥C, row_index≥R or col_index≥S, force that entry's glb_rd_addr to 0, still deliver the word, and clear it on reset or start.
REQ-023 SHALL, without FILTER_ADDR_CHECK_EN, omit addr_error and all range comparators, with addresses per REQ-010 unmodified.

Verification
REQ-024 SHALL cover: M=2,C=3,R=3,S=3, tuple (1,2,1,2) -> glb_rd_addr=50 one cycle after acceptance, out_valid three cycles after acceptance.
REQ-025 SHALL cover: out_ready=0, idx_valid held high -> exactly 4 tuples accepted, await=1 from the cycle after the 4th acceptance, 4 words delivered in order once out_ready=1.
REQ-026 SHALL cover: FIFO full with out_ready=1 and continuous idx_valid -> sustained one word per cycle after fill, no overflow, fifo_count stays ≤4.
REQ-027 SHALL cover: reset=0 asserted with 2 words buffered and 1 read pending -> next cycle out_valid=0, busy=0, word_count=0.
REQ-028 SHALL cover: FILTER_ADDR_CHECK_EN defined, row_index=3 with R=3 -> addr_error=1 and glb_rd_addr=0 for that read; start pulse -> addr_error=0 and word_count=0.
